// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin owner arbitration of one frame-buffer SRAM port
// among NUM_CH engines, with a burst cap, registered SRAM commands and
// per-channel read-return valids delayed by the SRAM read latency.
// Optional build macro: SRAM_ARB_PRIO0_EN (channel 0 gets fixed top priority
// and is never capped; its release does not advance the round-robin pointer).
module sram_port_arbiter #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DATA_W    = 1536,
    parameter int unsigned ADDR_W    = 24,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic [NUM_CH-1:0]          req,
    output logic [NUM_CH-1:0]          gnt,
    input  logic [NUM_CH-1:0]          ch_read_enable,
    input  logic [NUM_CH-1:0]          ch_write_enable,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_address,
    input  logic [NUM_CH*DATA_W-1:0]   ch_write_data,
    output logic [DATA_W-1:0]          ch_read_data,
    output logic [NUM_CH-1:0]          ch_rvalid,
    output logic                       read_enable,
    output logic                       write_enable,
    output logic [ADDR_W-1:0]          address,
    output logic [DATA_W-1:0]          write_data,
    input  logic [DATA_W-1:0]          read_data,
    output logic                       cmd_err
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned BC_W = $clog2(MAX_BURST) + 1;
    localparam logic [BC_W-1:0] BC_CAP = BC_W'(MAX_BURST - 1);
    localparam logic [BC_W-1:0] BC_SAT = {BC_W{1'b1}};
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t              state, state_nxt;
    logic [CH_W-1:0]     owner, owner_nxt;
    logic [CH_W-1:0]     rr_ptr, rr_ptr_nxt;
    logic [BC_W-1:0]     burst_cnt, burst_cnt_nxt;
    logic [NUM_CH-1:0]   gnt_nxt;

    logic                win_found;
    logic [CH_W-1:0]     win_idx;
    int unsigned         scan_idx;
    logic                other_req;
    logic                capped;

    logic [ADDR_W-1:0]   addr_arr  [NUM_CH];
    logic [DATA_W-1:0]   wdata_arr [NUM_CH];
    logic                granted;
    logic                sel_re, sel_we;
    logic                issue_re, issue_we, issue_err;

    logic [NUM_CH-1:0]   rd_pipe [RD_LAT+1];

    // Unpack per-channel address and write data buses
    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign addr_arr[g]  = ch_address[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = ch_write_data[g*DATA_W +: DATA_W];
    end

    // Winner search: first requester at or after rr_ptr, wrapping
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            scan_idx = (32'(rr_ptr) + i) % NUM_CH;
            if (!win_found && req[CH_W'(scan_idx)]) begin
                win_found = 1'b1;
                win_idx   = CH_W'(scan_idx);
            end
        end
`ifdef SRAM_ARB_PRIO0_EN
        if (req[0]) begin
            win_found = 1'b1;
            win_idx   = '0;
        end
`endif
    end

    // Someone other than the current owner is waiting
    assign other_req = |(req & ~gnt);

    // Cap reached while another channel waits; >= covers an owner that ran
    // past the cap alone before a competitor showed up
`ifdef SRAM_ARB_PRIO0_EN
    assign capped = (burst_cnt >= BC_CAP) && other_req && (owner != '0);
`else
    assign capped = (burst_cnt >= BC_CAP) && other_req;
`endif

    // Next-state and grant logic
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        gnt_nxt       = gnt;
        case (state)
            ST_IDLE: begin
                gnt_nxt       = '0;
                burst_cnt_nxt = '0;
                if (win_found) begin
                    state_nxt = ST_GRANT;
                    owner_nxt = win_idx;
                    gnt_nxt   = NUM_CH'(1) << win_idx;
                end
            end
            ST_GRANT: begin
                if (burst_cnt != BC_SAT) begin
                    burst_cnt_nxt = burst_cnt + BC_W'(1);
                end
                if (!req[owner] || capped) begin
                    state_nxt     = ST_IDLE;
                    gnt_nxt       = '0;
                    burst_cnt_nxt = '0;
                    rr_ptr_nxt    = (owner == CH_LAST) ? '0 : owner + CH_W'(1);
`ifdef SRAM_ARB_PRIO0_EN
                    if (owner == '0) begin
                        rr_ptr_nxt = rr_ptr;
                    end
`endif
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    // Arbiter state register
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state     <= ST_IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            gnt       <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
            gnt       <= gnt_nxt;
        end
    end

    // Owner command select; a read paired with a write is dropped
    always_comb begin
        granted   = |gnt;
        sel_re    = gnt[owner] & ch_read_enable[owner];
        sel_we    = gnt[owner] & ch_write_enable[owner];
        issue_we  = sel_we;
        issue_re  = sel_re & ~sel_we;
        issue_err = sel_re & sel_we;
    end

    // Registered SRAM command outputs and sticky command error
    always_ff @(posedge clk) begin
        if (n_rst) begin
            read_enable  <= 1'b0;
            write_enable <= 1'b0;
            address      <= '0;
            write_data   <= '0;
            cmd_err      <= 1'b0;
        end else begin
            read_enable  <= issue_re;
            write_enable <= issue_we;
            if (granted) begin
                address    <= addr_arr[owner];
                write_data <= wdata_arr[owner];
            end
            cmd_err <= cmd_err | issue_err;
        end
    end

    // Read-return channel tracking; stage 0 lines up with read_enable
    always_ff @(posedge clk) begin
        if (n_rst) begin
            for (int unsigned k = 0; k <= RD_LAT; k++) begin
                rd_pipe[k] <= '0;
            end
        end else begin
            rd_pipe[0] <= issue_re ? gnt : '0;
            for (int unsigned k = 1; k <= RD_LAT; k++) begin
                rd_pipe[k] <= rd_pipe[k-1];
            end
        end
    end

    assign ch_rvalid    = rd_pipe[RD_LAT];
    // Read data is broadcast; ch_rvalid tells each channel when it is theirs
    assign ch_read_data = read_data;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: stimulus pushes expected grants,
// SRAM commands and read returns; a negedge monitor pops and compares.
// Build with SRAM_ARB_PRIO0_EN defined to exercise the channel-0 priority path.
module tb_sram_port_arbiter;

    localparam int NC = 4;
    localparam int DW = 64;
    localparam int AW = 24;
    localparam int MB = 4;
    localparam int RL = 2;

    logic              clk = 1'b0;
    logic              n_rst = 1'b1;
    logic [NC-1:0]     req = '1;
    logic [NC-1:0]     gnt;
    logic [NC-1:0]     ch_read_enable = '0;
    logic [NC-1:0]     ch_write_enable = '0;
    logic [NC*AW-1:0]  ch_address = '0;
    logic [NC*DW-1:0]  ch_write_data = '0;
    logic [DW-1:0]     ch_read_data;
    logic [NC-1:0]     ch_rvalid;
    logic              read_enable;
    logic              write_enable;
    logic [AW-1:0]     address;
    logic [DW-1:0]     write_data;
    logic [DW-1:0]     read_data;
    logic              cmd_err;

    sram_port_arbiter #(
        .NUM_CH(NC), .DATA_W(DW), .ADDR_W(AW), .MAX_BURST(MB), .RD_LAT(RL)
    ) dut (
        .clk(clk), .n_rst(n_rst), .req(req), .gnt(gnt),
        .ch_read_enable(ch_read_enable), .ch_write_enable(ch_write_enable),
        .ch_address(ch_address), .ch_write_data(ch_write_data),
        .ch_read_data(ch_read_data), .ch_rvalid(ch_rvalid),
        .read_enable(read_enable), .write_enable(write_enable),
        .address(address), .write_data(write_data),
        .read_data(read_data), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic re; logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } cmd_t;
    typedef struct { logic [NC-1:0] ch; logic [DW-1:0] data; } rv_t;
    typedef struct { logic [NC-1:0] vec; int len; } gnt_t;

    cmd_t exp_cmd[$];
    rv_t  exp_rv[$];
    gnt_t exp_gnt[$];
    int   rv_due[$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [DW-1:0] data_fn(input logic [AW-1:0] a);
        return {40'hA1B2C3D4E5, a};
    endfunction

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void flag(input string name, input logic [127:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endfunction

    task automatic push_gnt(input logic [NC-1:0] v, input int len);
        gnt_t g;
        g.vec = v; g.len = len;
        exp_gnt.push_back(g);
    endtask

    task automatic push_cmd(input logic re, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_t c;
        c.re = re; c.we = we; c.addr = a; c.data = d;
        exp_cmd.push_back(c);
    endtask

    task automatic push_rv(input logic [NC-1:0] ch, input logic [DW-1:0] d);
        rv_t r;
        r.ch = ch; r.data = d;
        exp_rv.push_back(r);
    endtask

    // SRAM model: data for a sampled read appears RL cycles later
    logic [DW-1:0] mem_pipe [RL];
    always @(posedge clk) begin
        for (int k = RL - 1; k > 0; k--) mem_pipe[k] <= mem_pipe[k-1];
        mem_pipe[0] <= read_enable ? data_fn(address) : '0;
    end
    assign read_data = mem_pipe[RL-1];

    // Monitor: commands, read returns and grant runs against the queues
    logic [NC-1:0] prev_gnt = '0;
    int            run_len  = 0;
    int            cyc      = 0;
    gnt_t          cur;
    always @(negedge clk) begin
        cmd_t c;
        rv_t  r;
        cyc++;
        if (n_rst) begin
            prev_gnt = '0;
            run_len  = 0;
            rv_due.delete();
        end else begin
            if (read_enable || write_enable) begin
                if (exp_cmd.size() == 0) begin
                    flag("cmd_unexpected", 128'({read_enable, write_enable, address}));
                end else begin
                    c = exp_cmd.pop_front();
                    chk("cmd_re",   128'(read_enable),  128'(c.re));
                    chk("cmd_we",   128'(write_enable), 128'(c.we));
                    chk("cmd_addr", 128'(address),      128'(c.addr));
                    if (c.we) chk("cmd_wdata", 128'(write_data), 128'(c.data));
                end
                if (read_enable) rv_due.push_back(cyc + RL);
            end
            if (rv_due.size() > 0 && rv_due[0] == cyc) begin
                void'(rv_due.pop_front());
                if (exp_rv.size() == 0) begin
                    flag("rv_unexpected", 128'(ch_rvalid));
                end else begin
                    r = exp_rv.pop_front();
                    chk("rv_ch",   128'(ch_rvalid),    128'(r.ch));
                    chk("rv_data", 128'(ch_read_data), 128'(r.data));
                end
            end else if (ch_rvalid != '0) begin
                flag("rv_stray", 128'(ch_rvalid));
            end
            if (!$onehot0(gnt)) flag("gnt_not_onehot", 128'(gnt));
            if (gnt != '0 && prev_gnt == '0) begin
                if (exp_gnt.size() == 0) begin
                    flag("gnt_unexpected", 128'(gnt));
                    cur.vec = gnt; cur.len = 0;
                end else begin
                    cur = exp_gnt.pop_front();
                    chk("gnt_vec", 128'(gnt), 128'(cur.vec));
                end
                run_len = 1;
            end else if (gnt != '0 && gnt == prev_gnt) begin
                run_len++;
            end else if (gnt != '0) begin
                flag("gnt_abut", 128'({prev_gnt, gnt}));
            end else if (prev_gnt != '0 && cur.len != 0) begin
                chk("gnt_len", 128'(run_len), 128'(cur.len));
            end
            prev_gnt = gnt;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_gnt(input logic [NC-1:0] v, output int n);
        n = 0;
        while (gnt !== v && n < 50) begin
            tick(1);
            n++;
        end
        chk("wait_gnt", 128'(gnt), 128'(v));
    endtask

    task automatic do_reset();
        n_rst = 1'b1;
        req = '0;
        ch_read_enable = '0;
        ch_write_enable = '0;
        tick(3);
        n_rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int total;

        // Reset with all channels requesting
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_gnt",   128'(gnt),          128'(0));
            chk("rst_re",    128'(read_enable),  128'(0));
            chk("rst_we",    128'(write_enable), 128'(0));
            chk("rst_err",   128'(cmd_err),      128'(0));
            chk("rst_rvld",  128'(ch_rvalid),    128'(0));
        end
        @(posedge clk); #1;
        n_rst = 1'b0;
        req = '0;
        tick(2);

        // Single read from channel 2; owner drops req with the read in flight
        push_gnt(4'b0100, 2);
        req = 4'b0100;
        tick(1);
        chk("lat_gnt", 128'(gnt), 128'(4'b0100));
        ch_read_enable = 4'b0100;
        ch_address[2*AW +: AW] = 24'h000123;
        push_cmd(1'b1, 1'b0, 24'h000123, '0);
        push_rv(4'b0100, data_fn(24'h000123));
        tick(1);
        ch_read_enable = '0;
        req = '0;
        tick(6);

`ifndef SRAM_ARB_PRIO0_EN
        // Fairness: all request, each owner capped at MB cycles, order 0,1,2,3,0
        do_reset();
        push_gnt(4'b0001, MB);
        push_gnt(4'b0010, MB);
        push_gnt(4'b0100, MB);
        push_gnt(4'b1000, MB);
        push_gnt(4'b0001, 0);
        req = 4'b1111;
        total = 0;
        wait_gnt(4'b0001, n); total += n;
        wait_gnt(4'b0010, n); total += n;
        wait_gnt(4'b0100, n); total += n;
        wait_gnt(4'b1000, n); total += n;
        wait_gnt(4'b0001, n); total += n;
        chk("fair_timing", 128'(total), 128'(4 * (MB + 1) + 1));
        req = 4'b0001;
        tick(8);
        chk("solo_hold", 128'(gnt), 128'(4'b0001));
        req = '0;
        tick(3);
`endif

        // Pre-empt with a read on the last burst cycle; return still to ch1
        do_reset();
        push_gnt(4'b0010, MB);
        push_gnt(4'b0100, 1);
        req = 4'b0110;
        wait_gnt(4'b0010, n);
        tick(MB - 1);
        ch_read_enable = 4'b0010;
        ch_address[1*AW +: AW] = 24'h0000A1;
        push_cmd(1'b1, 1'b0, 24'h0000A1, '0);
        push_rv(4'b0010, data_fn(24'h0000A1));
        tick(1);
        ch_read_enable = '0;
        chk("pre_gap", 128'(gnt), 128'(0));
        wait_gnt(4'b0100, n);
        chk("pre_regrant_lat", 128'(n), 128'(1));
        req = '0;
        tick(6);

        // Plain write, ignored non-owner read, then read+write error
        do_reset();
        push_gnt(4'b0001, 0);
        req = 4'b0001;
        wait_gnt(4'b0001, n);
        ch_write_enable = 4'b0001;
        ch_read_enable = 4'b1000;
        ch_address[0 +: AW] = 24'h000055;
        ch_address[3*AW +: AW] = 24'hFFFFFF;
        ch_write_data[0 +: DW] = 64'h1122334455667788;
        push_cmd(1'b0, 1'b1, 24'h000055, 64'h1122334455667788);
        tick(1);
        ch_read_enable = 4'b0001;
        ch_address[0 +: AW] = 24'h00BEEF;
        ch_write_data[0 +: DW] = 64'hA5A5A5A5A5A5A5A5;
        push_cmd(1'b0, 1'b1, 24'h00BEEF, 64'hA5A5A5A5A5A5A5A5);
        chk("err_pre", 128'(cmd_err), 128'(0));
        tick(1);
        ch_read_enable = '0;
        ch_write_enable = '0;
        chk("err_set", 128'(cmd_err), 128'(1));
        tick(5);
        chk("err_sticky", 128'(cmd_err), 128'(1));
        req = '0;
        tick(3);
        n_rst = 1'b1;
        tick(1);
        chk("err_clr", 128'(cmd_err), 128'(0));
        n_rst = 1'b0;
        tick(1);

        // ch1 owns, ch0 and ch3 then wait
        do_reset();
`ifdef SRAM_ARB_PRIO0_EN
        push_gnt(4'b0010, MB);
        push_gnt(4'b0001, 0);
        req = 4'b1010;
        wait_gnt(4'b0010, n);
        req = 4'b1011;
        wait_gnt(4'b0001, n);
        chk("prio_win_lat", 128'(n), 128'(MB + 1));
        tick(2 * MB);
        chk("prio_hold", 128'(gnt), 128'(4'b0001));
        req = '0;
        tick(3);
`else
        push_gnt(4'b0010, MB);
        push_gnt(4'b1000, MB);
        push_gnt(4'b0001, 0);
        req = 4'b1010;
        wait_gnt(4'b0010, n);
        req = 4'b1011;
        wait_gnt(4'b1000, n);
        chk("rr_win_lat", 128'(n), 128'(MB + 1));
        wait_gnt(4'b0001, n);
        req = '0;
        tick(3);
`endif

        tick(4);
        chk("drain_cmd", 128'(exp_cmd.size()), 128'(0));
        chk("drain_rv",  128'(exp_rv.size()),  128'(0));
        chk("drain_gnt", 128'(exp_gnt.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
